// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: opcodes, default widths and
// the skid-buffer occupancy encoding.
// Imported by result_skid_buf and alu_result_stage.
package alu_result_stage_pkg;

   // Default datapath and counter widths
   localparam int N_DEF     = 32;
   localparam int CNT_W_DEF = 16;

   // Gate-array select codes
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   // Skid-buffer occupancy: no entries, main entry only, main + skid entries
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } buf_state_t;

endpackage

// File: rtl/result_skid_buf.sv
// Purpose: generic 2-entry valid/ready skid register (main + skid entry).
// Latency: one cycle, input accepted at edge k is visible on out_data after edge k.
// Backpressure: in_ready is registered (low only when both entries are full), no comb path from out_ready.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_data   upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload (always the main entry)
module result_skid_buf
   import alu_result_stage_pkg::*;
#(
   parameter int             W       = 34,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data
);

   buf_state_t     state_q, state_d;
   logic [W-1:0]   main_q, main_d;
   logic [W-1:0]   skid_q, skid_d;
   logic           rdy_q, rdy_d;
   logic           accept;
   logic           drain;

   assign accept = in_valid & rdy_q;
   assign drain  = (state_q != ST_EMPTY) & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               // main leaves and is replaced in the same cycle
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a drain can happen
            if (drain) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Ready is computed from the next state so it can be a plain flop output
      rdy_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Purpose: select one gate-array result by opcode, attach zero/parity flags, buffer it, count deliveries.
// Latency: one cycle from accept (edge k) to outval/out_valid (after edge k).
// Backpressure: 2-entry skid buffer; in_ready is registered and drops only when both entries hold data.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready, op             upstream handshake and opcode (AND/OR/XOR/NOR)
//   and_val/or_val/xor_val/nor_val    gate-array results
//   out_valid/out_ready               downstream handshake
//   outval, zero, parity              selected result and its stored flags
//   res_count                         wrapping count of output transfers since reset
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [N-1:0]     and_val,
   input  logic [N-1:0]     or_val,
   input  logic [N-1:0]     xor_val,
   input  logic [N-1:0]     nor_val,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     outval,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] res_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [N-1:0] sel_val;
   logic         sel_zero;
   logic         sel_par;
   logic [N+1:0] buf_in;
   logic [N+1:0] buf_out;

   always_comb begin
      sel_val = and_val;
      case (op)
         OP_AND: sel_val = and_val;
         OP_OR:  sel_val = or_val;
         OP_XOR: sel_val = xor_val;
         OP_NOR: sel_val = nor_val;
         default: sel_val = and_val;
      endcase
   end

   // Flags are computed once at the input and travel with the value, so the
   // output side never looks at live inputs.
   assign sel_zero = ~|sel_val;
   assign sel_par  = ^sel_val;
   assign buf_in   = {sel_par, sel_zero, sel_val};

   // Reset image of an entry: value 0, zero=1, parity=0
   result_skid_buf #(
      .W       (N + 2),
      .RST_VAL ({1'b0, 1'b1, {N{1'b0}}})
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (buf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign {parity, zero, outval} = buf_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_count <= '0;
      end else if (out_valid && out_ready) begin
         res_count <= res_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
   import alu_result_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] and_val = '0, or_val = '0, xor_val = '0, nor_val = '0;

   logic        in_ready, out_valid, zero, parity;
   logic [31:0] outval;
   logic [15:0] res_count;

   logic        w_in_ready, w_out_valid, w_zero, w_parity;
   logic [31:0] w_outval;
   logic [3:0]  w_res_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.N(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .and_val(and_val), .or_val(or_val), .xor_val(xor_val), .nor_val(nor_val),
      .out_valid(out_valid), .out_ready(out_ready), .outval(outval),
      .zero(zero), .parity(parity), .res_count(res_count)
   );

   // Narrow-counter instance sharing all inputs, for wrap behaviour
   alu_result_stage #(.N(32), .CNT_W(4)) dut_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
      .and_val(and_val), .or_val(or_val), .xor_val(xor_val), .nor_val(nor_val),
      .out_valid(w_out_valid), .out_ready(out_ready), .outval(w_outval),
      .zero(w_zero), .parity(w_parity), .res_count(w_res_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] pick(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] r, input logic [31:0] x,
                                        input logic [31:0] n);
      if (o == 2'd0) return a;
      if (o == 2'd1) return r;
      if (o == 2'd2) return x;
      return n;
   endfunction

   // ---------------- reference model: FIFO of accepted results ----------------
   logic [31:0] q[$];
   int          mcount = 0;
   bit          live = 0;
   bit          fresh = 0;
   bit          acc, drn;
   logic [31:0] e;

   always @(negedge clk) begin
      if (live) begin
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("res_count", 64'(res_count), 64'(mcount % 65536));
         chk("res_count_w4", 64'(w_res_count), 64'(mcount % 16));
         chk("w4_out_valid", 64'(w_out_valid), 64'(q.size() > 0));
         if (q.size() > 0) begin
            e = q[0];
            chk("outval", 64'(outval), 64'(e));
            chk("zero", 64'(zero), 64'(e == 32'd0));
            chk("parity", 64'(parity), 64'($countones(e) % 2));
            chk("w4_outval", 64'(w_outval), 64'(e));
         end else if (fresh) begin
            chk("rst_outval", 64'(outval), 64'd0);
            chk("rst_zero", 64'(zero), 64'd1);
            chk("rst_parity", 64'(parity), 64'd0);
         end
      end
      if (rst) begin
         q.delete();
         mcount = 0;
         live   = 1;
         fresh  = 1;
      end else if (live) begin
         acc = in_valid && (q.size() < 2);
         drn = (q.size() > 0) && out_ready;
         if (drn) begin
            void'(q.pop_front());
            mcount++;
         end
         if (acc) begin
            q.push_back(pick(op, and_val, or_val, xor_val, nor_val));
            fresh = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   logic [31:0] exp2[4];
   logic        exp2p[4];

   initial begin
      exp2  = '{32'hF0F0F0F0, 32'hFFFF0000, 32'h00000000, 32'h00000001};
      exp2p = '{1'b0, 1'b0, 1'b0, 1'b1};

      // 1. reset
      rst = 1; in_valid = 0; out_ready = 0;
      step(); step();
      chk("t1_out_valid", 64'(out_valid), 64'd0);
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      chk("t1_outval", 64'(outval), 64'd0);
      chk("t1_zero", 64'(zero), 64'd1);
      chk("t1_res_count", 64'(res_count), 64'd0);
      rst = 0;

      // 2. op select
      and_val = 32'hF0F0F0F0; or_val = 32'hFFFF0000; xor_val = 32'h0; nor_val = 32'h1;
      out_ready = 1; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         op = 2'(i);
         step();
         chk("t2_valid", 64'(out_valid), 64'd1);
         chk("t2_outval", 64'(outval), 64'(exp2[i]));
         chk("t2_parity", 64'(parity), 64'(exp2p[i]));
         chk("t2_zero", 64'(zero), 64'(exp2[i] == 32'd0));
      end
      in_valid = 0;
      step();
      chk("t2_drained", 64'(out_valid), 64'd0);

      // 3. backpressure
      out_ready = 0; op = OP_AND; in_valid = 1;
      and_val = 32'h11111111; step();
      and_val = 32'h22222222; step();
      chk("t3_full_rdy", 64'(in_ready), 64'd0);
      chk("t3_hold_a", 64'(outval), 64'h11111111);
      and_val = 32'h33333333; step();
      chk("t3_c_rejected_rdy", 64'(in_ready), 64'd0);
      chk("t3_still_a", 64'(outval), 64'h11111111);
      in_valid = 0; out_ready = 1; step();
      chk("t3_b_out", 64'(outval), 64'h22222222);
      chk("t3_rdy_back", 64'(in_ready), 64'd1);
      step();
      chk("t3_empty", 64'(out_valid), 64'd0);

      // 4. full throughput
      rst = 1; step(); rst = 0;
      out_ready = 1; in_valid = 1; op = OP_AND;
      for (int i = 0; i < 100; i++) begin
         and_val = 32'(i);
         step();
         chk("t4_outval", 64'(outval), 64'(i));
      end
      in_valid = 0;
      step();
      chk("t4_res_count", 64'(res_count), 64'd100);

      // 5. random handshakes, checked by the model
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         op        = 2'($urandom_range(0, 3));
         and_val   = $urandom; or_val = $urandom;
         xor_val   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         nor_val   = $urandom;
         step();
      end
      in_valid = 0; out_ready = 1;
      step(); step(); step();

      // 6. reset while full, then counter wrap
      rst = 1; step(); rst = 0;
      out_ready = 0; in_valid = 1; op = OP_OR; or_val = 32'hA5A5A5A5;
      step(); step();
      chk("t6_full", 64'(in_ready), 64'd0);
      rst = 1; step();
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_rdy", 64'(in_ready), 64'd1);
      chk("t6_rst_count", 64'(res_count), 64'd0);
      rst = 0; in_valid = 1; out_ready = 1;
      for (int i = 0; i < 17; i++) begin
         or_val = 32'(i + 1);
         step();
      end
      in_valid = 0;
      step();
      chk("t6_wrap_w4", 64'(w_res_count), 64'd1);
      chk("t6_count17", 64'(res_count), 64'd17);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
